// File: rtl/wb_mem_pkg.sv
// Shared types and constants for the Wishbone burst memory responder.
package wb_mem_pkg;

    localparam int unsigned WB_BL_W      = 10;
    localparam logic [3:0]  WB_MASK_FULL = 4'b1111;
    // Width of the shared latency/gap down-counter.
    localparam int unsigned WB_CNT_W     = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LAT   = 3'd1,
        RBEAT = 3'd2,
        WBEAT = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } wb_resp_state_e;

endpackage

// File: rtl/std_dffr.sv
// Plain register with synchronous active-low clear.
module std_dffr #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/wb_beat_counter.sv
// Burst bookkeeping: SRAM word pointer (wrapping) and remaining-beat count.
module wb_beat_counter
    import wb_mem_pkg::*;
#(
    parameter int unsigned MEM_AW = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               load,
    input  logic               adv,
    input  logic [MEM_AW-1:0]  load_ptr,
    input  logic [WB_BL_W-1:0] load_bl,
    output logic [MEM_AW-1:0]  ptr,
    output logic [MEM_AW-1:0]  ptr_inc_c,
    output logic               last_c
);

    logic [MEM_AW-1:0]  ptr_d;
    logic [WB_BL_W-1:0] bl_q;
    logic [WB_BL_W-1:0] bl_d;

    // Natural modulo-2^MEM_AW wrap of the word pointer.
    assign ptr_inc_c = ptr + MEM_AW'(1);
    assign last_c    = (bl_q == '0);

    always_comb begin
        ptr_d = ptr;
        bl_d  = bl_q;
        if (load) begin
            ptr_d = load_ptr;
            bl_d  = load_bl;
        end else if (adv) begin
            ptr_d = ptr_inc_c;
            bl_d  = bl_q - WB_BL_W'(1);
        end
    end

    std_dffr #(.WIDTH(MEM_AW)) u_ptr (
        .clk  (clk),
        .rstn (rstn),
        .d    (ptr_d),
        .q    (ptr)
    );

    std_dffr #(.WIDTH(WB_BL_W)) u_beats_left (
        .clk  (clk),
        .rstn (rstn),
        .d    (bl_d),
        .q    (bl_q)
    );

endmodule

// File: rtl/wb_burst_mem_responder.sv
// Wishbone-style burst responder serving cache refills from a single-port SRAM.
module wb_burst_mem_responder
    import wb_mem_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned MEM_AW   = 8,
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned BEAT_GAP = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [ADDR_LEN-1:0] wb_adr_i,
    input  logic [WB_BL_W-1:0]  wb_bl_i,
    input  logic                wb_bry_i,
    input  logic [DATA_LEN-1:0] wb_dat_i,
    output logic                wb_ack_o,
    output logic [DATA_LEN-1:0] wb_dat_o,
    output logic                mem_chip_en,
    output logic                mem_write_en,
    output logic [3:0]          mem_mask,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_LEN-1:0] mem_din,
    input  logic [DATA_LEN-1:0] mem_dout
);

    wb_resp_state_e     state;
    wb_resp_state_e     next_state;
    logic [2:0]         state_q;
    logic [WB_CNT_W-1:0] lat_q;
    logic [WB_CNT_W-1:0] lat_d;
    logic               we_q;
    logic               we_d;

    logic               req;
    logic               beat_ok;
    logic               cnt_load;
    logic               cnt_adv;
    logic               ack_c;
    logic               rd_c;
    logic               wr_c;
    logic               rd_next_c;
    logic [MEM_AW-1:0]  ptr;
    logic [MEM_AW-1:0]  ptr_inc_c;
    logic               last_c;
    logic               unused_adr;

    // Only the word-index slice of the byte address reaches the SRAM.
    assign unused_adr = ^{wb_adr_i[ADDR_LEN-1:MEM_AW+2], wb_adr_i[1:0]};

    assign req     = wb_cyc_i & wb_stb_i;
    assign beat_ok = req & wb_bry_i;
    assign state   = wb_resp_state_e'(state_q);

    always_comb begin
        next_state = state;
        lat_d      = lat_q;
        we_d       = we_q;
        cnt_load   = 1'b0;
        cnt_adv    = 1'b0;
        ack_c      = 1'b0;
        rd_c       = 1'b0;
        wr_c       = 1'b0;
        rd_next_c  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_load = 1'b1;
                    we_d     = wb_we_i;
                    if (wb_we_i) begin
                        next_state = WBEAT;
                    end else begin
                        next_state = LAT;
                        lat_d      = WB_CNT_W'(READ_LAT - 2);
                    end
                end
            end
            LAT: begin
                if (lat_q == '0) begin
                    rd_c       = 1'b1;
                    next_state = RBEAT;
                end else begin
                    lat_d = lat_q - WB_CNT_W'(1);
                end
            end
            RBEAT: begin
                if (beat_ok) begin
                    ack_c = 1'b1;
                    if (last_c) begin
                        next_state = DONE;
                    end else begin
                        cnt_adv = 1'b1;
                        if (BEAT_GAP == 0) begin
                            // Back-to-back beats: fetch the next word during this ack.
                            rd_c      = 1'b1;
                            rd_next_c = 1'b1;
                        end else begin
                            next_state = GAP;
                            lat_d      = WB_CNT_W'(BEAT_GAP - 1);
                        end
                    end
                end else begin
                    // Stalled: keep re-reading so mem_dout tracks the current word.
                    rd_c = 1'b1;
                end
            end
            WBEAT: begin
                if (beat_ok) begin
                    ack_c = 1'b1;
                    wr_c  = 1'b1;
                    if (last_c) begin
                        next_state = DONE;
                    end else begin
                        cnt_adv = 1'b1;
                        if (BEAT_GAP != 0) begin
                            next_state = GAP;
                            lat_d      = WB_CNT_W'(BEAT_GAP - 1);
                        end
                    end
                end
            end
            GAP: begin
                if (lat_q == '0) begin
                    next_state = we_q ? WBEAT : RBEAT;
                    rd_c       = ~we_q;
                end else begin
                    lat_d = lat_q - WB_CNT_W'(1);
                end
            end
            DONE: begin
                if (!wb_cyc_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Reset blanks every bus and SRAM output in the cycle it is applied.
    assign wb_ack_o     = rstn & ack_c;
    assign wb_dat_o     = (rstn & ack_c & (state == RBEAT)) ? mem_dout : '0;
    assign mem_chip_en  = ~(rstn & (rd_c | wr_c));
    assign mem_write_en = ~(rstn & wr_c);
    assign mem_mask     = (rstn & wr_c) ? WB_MASK_FULL : 4'b0000;
    assign mem_addr     = (rstn & (rd_c | wr_c)) ? (rd_next_c ? ptr_inc_c : ptr) : '0;
    assign mem_din      = (rstn & wr_c) ? wb_dat_i : '0;

    std_dffr #(.WIDTH(3)) u_state (
        .clk  (clk),
        .rstn (rstn),
        .d    (3'(next_state)),
        .q    (state_q)
    );

    std_dffr #(.WIDTH(WB_CNT_W)) u_lat_cnt (
        .clk  (clk),
        .rstn (rstn),
        .d    (lat_d),
        .q    (lat_q)
    );

    std_dffr #(.WIDTH(1)) u_we (
        .clk  (clk),
        .rstn (rstn),
        .d    (we_d),
        .q    (we_q)
    );

    wb_beat_counter #(.MEM_AW(MEM_AW)) u_beat_counter (
        .clk       (clk),
        .rstn      (rstn),
        .load      (cnt_load),
        .adv       (cnt_adv),
        .load_ptr  (wb_adr_i[MEM_AW+1:2]),
        .load_bl   (wb_bl_i),
        .ptr       (ptr),
        .ptr_inc_c (ptr_inc_c),
        .last_c    (last_c)
    );

endmodule

// File: tb/tb_wb_burst_mem_responder.sv
// Randomized bench for wb_burst_mem_responder with an SRAM model and a burst-timing reference.
module tb_wb_burst_mem_responder;

    localparam int unsigned READ_LAT = 2;
    localparam int unsigned BEAT_GAP = 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_bry_i;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [9:0]  wb_bl_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        mem_chip_en, mem_write_en;
    logic [3:0]  mem_mask;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] sram    [256];
    logic [31:0] ref_mem [256];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_burst_mem_responder #(
        .ADDR_LEN(32), .DATA_LEN(32), .MEM_AW(8), .READ_LAT(READ_LAT), .BEAT_GAP(BEAT_GAP)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_bl_i(wb_bl_i), .wb_bry_i(wb_bry_i), .wb_dat_i(wb_dat_i),
        .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
        .mem_chip_en(mem_chip_en), .mem_write_en(mem_write_en), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Synchronous SRAM model with a back-door loader.
    always @(posedge clk) begin
        if (ld_en) begin
            sram[ld_addr] <= ld_data;
        end else if (!mem_chip_en) begin
            if (!mem_write_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) sram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
            end else begin
                mem_dout <= sram[mem_addr];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        ref_mem[a] = d;
        next_cycle();
        ld_en = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        tests++;
        if ({wb_ack_o, wb_dat_o, mem_chip_en, mem_write_en, mem_mask, mem_addr, mem_din} !==
            {1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0}) begin
            fails++;
            $display("FAIL %s: ack=%b dat=%h ce=%b we=%b mask=%h addr=%h din=%h, want idle values",
                     name, wb_ack_o, wb_dat_o, mem_chip_en, mem_write_en, mem_mask, mem_addr, mem_din);
        end
    endtask

    // Reference rule: beat k acks on the first cycle at or after its earliest slot
    // where the master presents cyc&stb&bry; next slot is last ack + BEAT_GAP + 1.
    task automatic run_burst(input bit we, input logic [31:0] adr, input int bl,
                             input int stall_pct, input int drop_at,
                             input int bry_lo_from, input int bry_lo_len,
                             input int linger, input bit rand_data,
                             output int last_ack_off);
        logic [31:0] wdata[$];
        logic [7:0]  wa, a;
        int          k, off, earliest;
        bit          rdy_cyc, rdy_bry, exp_ack;
        wa = adr[9:2];
        for (int i = 0; i <= bl; i++) wdata.push_back(rand_data ? $urandom : 32'(i + 1));
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
        wb_bl_i = 10'(bl); wb_bry_i = 1'b1; wb_dat_i = wdata[0];
        @(negedge clk);
        tests++;
        if (wb_ack_o !== 1'b0) begin
            fails++; $display("FAIL accept_ack: got %b want 0", wb_ack_o);
        end
        next_cycle();
        k = 0; off = 1; last_ack_off = -1;
        earliest = we ? 1 : int'(READ_LAT);
        while (k <= bl) begin
            if (off > 300) begin
                tests++; fails++;
                $display("FAIL burst_timeout: beats acked %0d want %0d", k, bl + 1);
                break;
            end
            rdy_cyc = (off != drop_at);
            rdy_bry = !(off >= bry_lo_from && off < bry_lo_from + bry_lo_len) &&
                      (int'($urandom_range(99)) >= stall_pct);
            wb_cyc_i = rdy_cyc; wb_stb_i = 1'b1; wb_bry_i = rdy_bry;
            wb_adr_i = $urandom; wb_bl_i = 10'($urandom); wb_we_i = 1'($urandom);
            wb_dat_i = wdata[k];
            exp_ack = (off >= earliest) && rdy_cyc && rdy_bry;
            a = wa + 8'(k);
            @(negedge clk);
            tests++;
            if (wb_ack_o !== exp_ack) begin
                fails++; $display("FAIL ack off=%0d beat=%0d: got %b want %b", off, k, wb_ack_o, exp_ack);
            end
            if (exp_ack) begin
                tests++;
                if (we) begin
                    if ({mem_chip_en, mem_write_en, mem_mask, mem_addr, mem_din} !==
                        {1'b0, 1'b0, 4'hF, a, wdata[k]}) begin
                        fails++;
                        $display("FAIL write_beat %0d: ce=%b we=%b mask=%h addr=%h din=%h want 0 0 f %h %h",
                                 k, mem_chip_en, mem_write_en, mem_mask, mem_addr, mem_din, a, wdata[k]);
                    end
                    ref_mem[a] = wdata[k];
                end else if (wb_dat_o !== ref_mem[a]) begin
                    fails++; $display("FAIL read_data beat %0d: got %h want %h", k, wb_dat_o, ref_mem[a]);
                end
                k++;
                earliest = off + int'(BEAT_GAP) + 1;
                last_ack_off = off;
            end else begin
                tests++;
                if (mem_write_en !== 1'b1) begin
                    fails++; $display("FAIL stray_write off=%0d: write_en=%b want 1", off, mem_write_en);
                end
            end
            next_cycle();
            off++;
        end
        for (int i = 0; i < linger; i++) begin
            wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_bry_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = $urandom;
            @(negedge clk);
            tests++;
            if (wb_ack_o !== 1'b0 || mem_chip_en !== 1'b1) begin
                fails++; $display("FAIL done_linger: ack=%b ce=%b want 0 1", wb_ack_o, mem_chip_en);
            end
            next_cycle();
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_bry_i = 1'b0;
        @(negedge clk);
        tests++;
        if (wb_ack_o !== 1'b0 || mem_chip_en !== 1'b1) begin
            fails++; $display("FAIL done_release: ack=%b ce=%b want 0 1", wb_ack_o, mem_chip_en);
        end
        next_cycle();
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_bry_i = 1'b1; wb_adr_i = 32'h40;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_idle_outputs("reset_hold");
            next_cycle();
        end
        rstn = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("reset_wins_over_request");
            next_cycle();
        end
    endtask

    task automatic test_read_basic;
        int last;
        load_word(8'h42, 32'hAAAA_0001);
        load_word(8'h43, 32'hAAAA_0002);
        run_burst(1'b0, 32'h108, 1, 0, -1, 0, 0, 0, 1'b0, last);
        tests++;
        if (last !== 4) begin fails++; $display("FAIL read_basic_last_ack: got %0d want 4", last); end
    endtask

    task automatic test_cyc_drop;
        int last;
        run_burst(1'b0, 32'h108, 1, 0, 3, 0, 0, 0, 1'b0, last);
        tests++;
        if (last !== 4) begin fails++; $display("FAIL cyc_drop_gap: got %0d want 4", last); end
        run_burst(1'b0, 32'h108, 1, 0, 4, 0, 0, 0, 1'b0, last);
        tests++;
        if (last !== 5) begin fails++; $display("FAIL cyc_drop_beat: got %0d want 5", last); end
    endtask

    task automatic test_write_wrap;
        int last;
        logic [31:0] got;
        logic [7:0]  w;
        run_burst(1'b1, 32'h3F8, 3, 0, -1, 0, 0, 0, 1'b0, last);
        for (int i = 0; i < 4; i++) begin
            w = 8'hFE + 8'(i);
            got = sram[w];
            tests++;
            if (got !== 32'(i + 1)) begin
                fails++; $display("FAIL write_wrap word %h: got %h want %h", w, got, 32'(i + 1));
            end
        end
    endtask

    task automatic test_bry_stall;
        int last;
        run_burst(1'b0, 32'h108, 1, 0, -1, 4, 3, 0, 1'b0, last);
        tests++;
        if (last !== 7) begin fails++; $display("FAIL bry_stall_last_ack: got %0d want 7", last); end
    endtask

    task automatic test_back_to_back;
        int last;
        run_burst(1'b0, 32'h3FC, 2, 0, -1, 0, 0, 1, 1'b0, last);
        run_burst(1'b1, 32'h020, 1, 0, -1, 0, 0, 2, 1'b1, last);
        run_burst(1'b0, 32'h020, 1, 0, -1, 0, 0, 0, 1'b0, last);
    endtask

    task automatic test_reset_midburst;
        int last;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_bry_i = 1'b1;
        wb_adr_i = 32'h108; wb_bl_i = 10'd3;
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== ref_mem[8'h42]) begin
            fails++; $display("FAIL midreset_beat0: ack=%b dat=%h want 1 %h", wb_ack_o, wb_dat_o, ref_mem[8'h42]);
        end
        next_cycle();
        rstn = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset_cycle");
        next_cycle();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_idle_outputs("midreset_after");
            next_cycle();
        end
        run_burst(1'b0, 32'h108, 3, 0, -1, 0, 0, 0, 1'b0, last);
        tests++;
        if (last !== 8) begin fails++; $display("FAIL midreset_fresh_last_ack: got %0d want 8", last); end
    endtask

    task automatic test_random;
        int last;
        for (int n = 0; n < 24; n++) begin
            run_burst(1'($urandom), $urandom, int'($urandom_range(7)), 25,
                      ($urandom_range(1) != 0) ? int'($urandom_range(1, 10)) : -1,
                      0, 0, int'($urandom_range(2)), 1'b1, last);
        end
        for (int n = 0; n < 8; n++) begin
            run_burst(1'b0, $urandom, int'($urandom_range(7)), 25, -1, 0, 0, 0, 1'b0, last);
        end
    endtask

    initial begin
        rstn = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_bry_i = 1'b0;
        wb_adr_i = '0; wb_bl_i = '0; wb_dat_i = '0;
        next_cycle();
        for (int i = 0; i < 256; i++) load_word(8'(i), $urandom);
        test_reset();
        test_read_basic();
        test_cyc_drop();
        test_write_wrap();
        test_bry_stall();
        test_back_to_back();
        test_reset_midburst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
